// File: rtl/board_access_ctrl.sv
// Single-port arbiter for the 20x10 gameboard RAM: renderer reads, game-logic writes,
// and a line-clear sequencer that drops full rows and compacts the board downward.
module board_access_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [4:0]    rd_row,
  input  logic [3:0]    rd_col,
  output logic          rd_valid,
  output logic [CW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [4:0]    wr_row,
  input  logic [3:0]    wr_col,
  input  logic [CW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [4:0]    lines_cleared,
  output logic [7:0]    ram_addr,
  output logic          ram_we,
  output logic [CW-1:0] ram_wdata,
  input  logic [CW-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, NEXT, FILL, DONE} state_t;
  typedef struct packed {
    logic [7:0]    addr;
    logic          we;
    logic [CW-1:0] wdata;
  } ram_req_t;

  state_t                  state, state_nx;
  logic [5:0]              src, dst, src_nx, dst_nx;
  logic [3:0]              col, col_nx, own_col;
  logic [4:0]              lines_nx;
  logic [COLS-1:0][CW-1:0] rbuf;
  logic                    own_fsm, rd_pend, rd_inr;
  logic                    rd_grant, wr_grant, wr_ok, fsm_req, fsm_grant, row_full, last_col;
  logic [5:0]              fsm_row;
  ram_req_t                req;

  function automatic logic [7:0] cell_addr(input logic [5:0] r, input logic [3:0] c);
    return 8'(r) * 8'(COLS) + 8'(c);
  endfunction

  always_comb begin
    rd_grant  = rd_req && (rd_row < 5'(ROWS)) && (rd_col < 4'(COLS));
    wr_ok     = (wr_row < 5'(ROWS)) && (wr_col < 4'(COLS));
    wr_grant  = (state == IDLE) && !clr_start && !rd_req && wr_req && !wr_ack;
    fsm_req   = state inside {READ, WRITE, FILL};
    fsm_grant = fsm_req && !rd_grant;
    fsm_row   = (state == READ) ? src : dst;
    last_col  = (col == 4'(COLS-1));
    row_full  = 1'b1;
    for (int i = 0; i < COLS; i++)
      if (rbuf[i] == '0) row_full = 1'b0;

    req = '0;
    if (rd_grant) begin
      req.addr = cell_addr({1'b0, rd_row}, rd_col);
    end else if (fsm_grant) begin
      req.addr  = cell_addr(fsm_row, col);
      req.we    = (state != READ);
      req.wdata = (state == WRITE) ? rbuf[col] : '0;
    end else if (wr_grant && wr_ok) begin
      req.addr  = cell_addr({1'b0, wr_row}, wr_col);
      req.we    = 1'b1;
      req.wdata = wr_data;
    end
    // Port outputs are combinational; force them low while reset is held.
    if (!rst) req = '0;
  end

  assign ram_addr  = req.addr;
  assign ram_we    = req.we;
  assign ram_wdata = req.wdata;
  assign rd_data   = (rst && rd_inr) ? ram_rdata : '0;
  assign clr_busy  = (state != IDLE);
  assign clr_done  = (state == DONE);

  always_comb begin
    state_nx = state;
    src_nx   = src;
    dst_nx   = dst;
    col_nx   = col;
    lines_nx = lines_cleared;
    case (state)
      IDLE: if (clr_start) begin
        src_nx   = 6'(ROWS-1);
        dst_nx   = 6'(ROWS-1);
        col_nx   = '0;
        lines_nx = '0;
        state_nx = READ;
      end
      READ: if (fsm_grant) begin
        col_nx = last_col ? 4'd0 : col + 4'd1;
        if (last_col) state_nx = EVAL;
      end
      EVAL: if (!own_fsm) begin
        if (row_full) begin
          if (lines_cleared < 5'(ROWS)) lines_nx = lines_cleared + 5'd1;
          state_nx = NEXT;
        end else if (dst == src) begin
          dst_nx   = dst - 6'd1;
          state_nx = NEXT;
        end else begin
          state_nx = WRITE;
        end
      end
      WRITE: if (fsm_grant) begin
        col_nx = last_col ? 4'd0 : col + 4'd1;
        if (last_col) begin
          dst_nx   = dst - 6'd1;
          state_nx = NEXT;
        end
      end
      // dst below zero means every row was kept, so nothing is left to blank.
      NEXT: if (src == 6'd0) state_nx = dst[5] ? DONE : FILL;
            else begin
              src_nx   = src - 6'd1;
              state_nx = READ;
            end
      FILL: if (fsm_grant) begin
        col_nx = last_col ? 4'd0 : col + 4'd1;
        if (last_col) begin
          if (dst == 6'd0) state_nx = DONE;
          else dst_nx = dst - 6'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      col           <= '0;
      lines_cleared <= '0;
      own_fsm       <= 1'b0;
      own_col       <= '0;
      rd_pend       <= 1'b0;
      rd_inr        <= 1'b0;
      wr_ack        <= 1'b0;
    end else begin
      state         <= state_nx;
      src           <= src_nx;
      dst           <= dst_nx;
      col           <= col_nx;
      lines_cleared <= lines_nx;
      own_fsm       <= fsm_grant && (state == READ);
      own_col       <= col;
      rd_pend       <= rd_req;
      rd_inr        <= rd_grant;
      wr_ack        <= wr_grant;
    end
  end

  assign rd_valid = rd_pend;

  always_ff @(posedge clk)
    if (own_fsm) rbuf[own_col] <= ram_rdata;

endmodule

// File: tb/tb_board_access_ctrl.sv
// Randomized bench for board_access_ctrl with a behavioural RAM and a row-compaction
// reference model of the board.
module tb_board_access_ctrl;
  localparam int ROWS = 20, COLS = 10, CW = 3, CELLS = ROWS * COLS;

  logic          clk = 1'b0, rst;
  logic          rd_req, rd_valid, wr_req, wr_ack, clr_start, clr_busy, clr_done, ram_we;
  logic [4:0]    rd_row, wr_row, lines_cleared;
  logic [3:0]    rd_col, wr_col;
  logic [CW-1:0] rd_data, wr_data, ram_wdata, ram_rdata;
  logic [7:0]    ram_addr;

  logic [CW-1:0] mem   [0:255];
  int            ref_b [0:CELLS-1];
  int n_cmp = 0, n_bad = 0, n_we = 0, pend_exp = 0;
  bit pend = 0, rnd_rd = 0;

  always #5 clk = ~clk;

  board_access_ctrl #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .lines_cleared(lines_cleared),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic rd_issue(input int r, input int c);
    rd_req = 1'b1; rd_row = 5'(r); rd_col = 4'(c);
    pend = 1;
    pend_exp = (r < ROWS && c < COLS) ? int'(mem[r*COLS+c]) : 0;
  endtask

  // One clock: behavioural RAM, renderer response check, optional random read.
  task automatic tick();
    logic [7:0] a; logic we; logic [CW-1:0] wd;
    #1;
    a = ram_addr; we = ram_we; wd = ram_wdata;
    if (we) n_we++;
    @(posedge clk);
    ram_rdata <= mem[a];
    if (we) mem[a] = wd;
    #1;
    if (pend) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, pend_exp);
    end else chk("rd_idle", rd_valid, 0);
    pend = 0;
    rd_req = 1'b0;
    if (rnd_rd && $urandom_range(0, 1) == 1) rd_issue($urandom_range(0, 21), $urandom_range(0, 11));
  endtask

  task automatic set_cell(input int r, input int c, input int v);
    mem[r*COLS+c] = CW'(v); ref_b[r*COLS+c] = v;
  endtask

  task automatic clear_board();
    for (int i = 0; i < CELLS; i++) begin mem[i] = '0; ref_b[i] = 0; end
  endtask

  task automatic random_board();
    for (int r = 0; r < ROWS; r++) begin
      bit full = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < COLS; c++)
        set_cell(r, c, full ? $urandom_range(1, 7) : $urandom_range(0, 7));
    end
  endtask

  // Reference: keep non-full rows in order, stack them at the bottom, zero the rest.
  function automatic int model_clear();
    int nb [0:CELLS-1];
    int k = ROWS - 1, lines = 0;
    for (int i = 0; i < CELLS; i++) nb[i] = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      bit full = 1;
      for (int c = 0; c < COLS; c++) if (ref_b[r*COLS+c] == 0) full = 0;
      if (full) lines++;
      else begin
        for (int c = 0; c < COLS; c++) nb[k*COLS+c] = ref_b[r*COLS+c];
        k--;
      end
    end
    for (int i = 0; i < CELLS; i++) ref_b[i] = nb[i];
    return (lines > ROWS) ? ROWS : lines;
  endfunction

  task automatic chk_board(input string tag);
    int bad = 0;
    for (int i = 0; i < CELLS; i++) if (int'(mem[i]) != ref_b[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic run_clear(input bit restart, input bit no_ack);
    int ndone = 0;
    bit fin = 0;
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    chk("busy_rise", clr_busy, 1);
    for (int i = 0; i < 8000 && !fin; i++) begin
      if (restart && i == 40) clr_start = 1'b1;
      tick(); clr_start = 1'b0;
      if (clr_done) ndone++;
      if (no_ack && clr_busy) chk("ack_busy", wr_ack, 0);
      if (!clr_busy) fin = 1;
    end
    if (!fin) chk("clr_timeout", 0, 1);
    chk("done_pulses", ndone, 1);
  endtask

  task automatic wr_do(input int r, input int c, input int v);
    bit got = 0;
    wr_req = 1'b1; wr_row = 5'(r); wr_col = 4'(c); wr_data = CW'(v);
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (wr_ack) got = 1;
    end
    chk("wr_ack_seen", got, 1);
    wr_req = 1'b0;
    if (r < ROWS && c < COLS) ref_b[r*COLS+c] = v;
  endtask

  task automatic quiesce();
    rnd_rd = 0; tick();
  endtask

  initial begin
    int lines, w0;
    bit hit;
    rst = 1'b0; rd_req = 0; rd_row = 0; rd_col = 0; wr_req = 0; wr_row = 0; wr_col = 0;
    wr_data = 0; clr_start = 0; ram_rdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    clear_board();
    tick(); tick();
    chk("rst_valid", rd_valid, 0); chk("rst_data", rd_data, 0);
    chk("rst_ack", wr_ack, 0);     chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);  chk("rst_lines", lines_cleared, 0);
    chk("rst_addr", ram_addr, 0);  chk("rst_we", ram_we, 0);
    rst = 1'b1; tick();

    // Renderer: corner cell and out-of-range row.
    set_cell(19, 9, 2); set_cell(0, 0, 5);
    rd_issue(19, 9); #1;
    chk("rd_addr199", ram_addr, 199); chk("rd_we", ram_we, 0);
    tick();
    rd_issue(20, 0); #1;
    chk("oor_we", ram_we, 0); chk("oor_addr", ram_addr, 0);
    tick(); tick();

    // Write blocked by renderer for three cycles.
    wr_req = 1'b1; wr_row = 5; wr_col = 3; wr_data = 1;
    for (int i = 0; i < 3; i++) begin
      rd_issue($urandom_range(0, 19), $urandom_range(0, 9)); #1;
      chk("wr_blocked", ram_we, 0);
      tick();
    end
    #1;
    chk("wr_we", ram_we, 1); chk("wr_addr53", ram_addr, 53); chk("wr_wdata", ram_wdata, 1);
    chk("wr_ack_early", wr_ack, 0);
    tick();
    chk("wr_ack", wr_ack, 1);
    wr_req = 1'b0; ref_b[53] = 1;
    tick();
    chk("wr_ack_pulse", wr_ack, 0);
    chk_board("after_write");

    // Rows 19 and 17 full, row 18 holds a single cell.
    clear_board();
    for (int c = 0; c < COLS; c++) begin
      set_cell(19, c, $urandom_range(1, 7)); set_cell(17, c, $urandom_range(1, 7));
    end
    set_cell(18, 0, 1);
    lines = model_clear();
    run_clear(0, 0);
    chk("lines_plan", lines_cleared, 2);
    chk("lines_model", lines_cleared, lines);
    chk("cell_19_0", mem[190], 1);
    chk_board("plan_board");

    // Empty board: no writes at all.
    clear_board();
    w0 = n_we;
    run_clear(0, 0);
    chk("empty_writes", n_we - w0, 0);
    chk("empty_lines", lines_cleared, 0);

    // Fully populated board saturates the count at ROWS.
    for (int i = 0; i < CELLS; i++) begin mem[i] = CW'($urandom_range(1, 7)); ref_b[i] = int'(mem[i]); end
    lines = model_clear();
    run_clear(0, 0);
    chk("full_lines", lines_cleared, ROWS);
    chk("full_model", lines, ROWS);
    chk_board("full_board");

    // Held write and a second start during a clear.
    random_board();
    lines = model_clear();
    wr_req = 1'b1; wr_row = 2; wr_col = 2; wr_data = 6;
    run_clear(1, 1);
    chk("hold_lines", lines_cleared, lines);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin tick(); if (wr_ack) hit = 1; end
    chk("late_ack", hit, 1);
    wr_req = 1'b0; ref_b[22] = 6;
    tick();
    chk_board("hold_board");

    // Reset while the sequencer is writing a compacted row.
    clear_board();
    for (int c = 0; c < COLS; c++) set_cell(19, c, $urandom_range(1, 7));
    set_cell(18, 4, 3); set_cell(10, 1, 7);
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      tick(); #1;
      if (clr_busy && ram_we) hit = 1;
    end
    chk("reached_write", hit, 1);
    rst = 1'b0; #1;
    chk("ar_busy", clr_busy, 0); chk("ar_done", clr_done, 0); chk("ar_we", ram_we, 0);
    chk("ar_addr", ram_addr, 0); chk("ar_wdata", ram_wdata, 0); chk("ar_lines", lines_cleared, 0);
    chk("ar_ack", wr_ack, 0);    chk("ar_valid", rd_valid, 0);
    tick(); tick();
    rst = 1'b1; tick();
    for (int i = 0; i < CELLS; i++) ref_b[i] = int'(mem[i]);
    lines = model_clear();
    run_clear(0, 0);
    chk("post_rst_lines", lines_cleared, lines);
    chk_board("post_rst_board");

    // Random boards, writes and clears under random renderer traffic.
    for (int it = 0; it < 6; it++) begin
      quiesce();
      random_board();
      rnd_rd = 1;
      for (int k = 0; k < 3; k++)
        wr_do($urandom_range(0, 21), $urandom_range(0, 11), $urandom_range(0, 7));
      lines = model_clear();
      run_clear(0, 0);
      chk("rnd_lines", lines_cleared, lines);
      quiesce();
      chk_board("rnd_board");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/board_access_ctrl.md
Name: board_access_ctrl

Overview:
- Owns the single port of the 20x10 gameboard RAM (3-bit colour code per cell) and shares it among three requesters: the VGA renderer's cell fetches, game-logic single-cell writes, and a line-clear sequencer.
- The line-clear sequencer removes full rows and compacts the board downward.
- Sits between game logic and the board memory; the renderer reads the board only through this block.

Parameters:
- ROWS, 20, game rows (row 0 = top).
- COLS, 10, game columns.
- CW, 3, cell width in bits; a value of 0 means an empty cell.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rd_req  in  1  renderer read request, single cycle
- rd_row  in  5  renderer cell row
- rd_col  in  4  renderer cell column
- rd_valid  out  1  renderer data valid
- rd_data  out  CW  renderer cell data
- wr_req  in  1  game-logic write request, held until ack
- wr_row  in  5  write row
- wr_col  in  4  write column
- wr_data  in  CW  write data
- wr_ack  out  1  single-cycle pulse: write performed or discarded
- clr_start  in  1  start line clear, single-cycle pulse
- clr_busy  out  1  line clear in progress
- clr_done  out  1  single-cycle pulse at completion
- lines_cleared  out  5  number of full rows removed by the last clear
- ram_addr  out  8  RAM address = row*COLS + col
- ram_we  out  1  RAM write enable
- ram_wdata  out  CW  RAM write data
- ram_rdata  in  CW  RAM read data; valid the cycle after a read address is presented

Behaviour:
- Reset: all outputs 0, FSM in IDLE. RAM contents are not modified by reset.
- Reset mid-clear: the clear aborts immediately, no clr_done is issued, and the board is left partially compacted.
- One RAM access per cycle. Fixed priority: renderer > clear FSM > single write.
  - The renderer is never stalled.
  - A requester that loses arbitration retries the same access on the next cycle, with no state advance.
- Renderer path:
  - In-range rd_req is granted the same cycle.
  - rd_valid=1 with rd_data=ram_rdata exactly 1 cycle later.
  - Out-of-range rd_req (row>=ROWS or col>=COLS) uses no port cycle; the response is rd_valid=1, rd_data=0 one cycle later.
- Write path:
  - Granted only when the FSM is IDLE, no clr_start is present that cycle, and rd_req=0.
  - wr_ack is asserted the cycle after the grant.
  - Out-of-range write: acked with ram_we=0.
  - wr_req is never acked while clr_busy=1.
- Read-owner tracking: a 1-cycle owner tag routes ram_rdata either to rd_data or to the FSM row buffer (index = issued column).
- clr_start:
  - Sampled only in IDLE; ignored while busy.
  - clr_busy rises the next cycle.
  - lines_cleared clears to 0 at start and holds its final value until the next start.
- FSM registers: src (row), dst (row), col counter, 10-entry row buffer.
  - IDLE: on clr_start, src=dst=ROWS-1 and go to READ.
  - READ: issue reads for columns 0..COLS-1 of src, one per won cycle. After the last read is issued, go to EVAL.
  - EVAL: wait until the last read data has been captured.
    - If all buffered cells are nonzero: lines_cleared++ and go to NEXT.
    - Else if dst==src: dst-- and go to NEXT.
    - Else go to WRITE.
  - WRITE: write buffer[0..COLS-1] to row dst, one per won cycle, then dst-- and go to NEXT.
  - NEXT: if src==0 go to FILL, else src-- and go to READ.
  - FILL: write 0 to every cell of rows dst down to 0. If no row was cleared (dst has wrapped below 0), skip FILL. Then go to DONE.
  - DONE: clr_done=1 for one cycle, clr_busy=0 on the following cycle, return to IDLE.
- Row and dst counters are 6 bits wide so that dst can reach -1 without aliasing.
- Width rules:
  - ram_addr is computed as row*COLS + col in 8 bits; maximum 199.
  - lines_cleared saturates at ROWS.

Test Plan:
- Renderer read of cell (19,9) preloaded with 3'd2 → ram_addr=199; rd_valid=1, rd_data=2 one cycle later. Read of row 20 → rd_data=0, no ram access.
- wr_req (5,3,3'd1) with rd_req held high for 3 cycles → ram_we stays 0 for those 3 cycles; write to addr 53 on the 4th cycle; wr_ack the following cycle.
- Rows 19 and 17 full, row 18 containing a single 3'd1 at column 0, all other rows empty → after clr_done, lines_cleared=2, row 19 col 0 = 1, all other cells = 0.
- Empty board clear → lines_cleared=0, zero RAM writes, clr_done asserted.
- During a clear, wr_req held high and clr_start pulsed again → no wr_ack until after clr_done; the second start is ignored (only one clr_done).
- Reset asserted while in the WRITE state → all outputs 0 asynchronously; a subsequent clr_start runs normally and clr_busy rises the cycle after.
